// File: rtl/sudoku_pkg.sv
// Shared constants, slot-ring entry type and grid helper for the sudoku scheduler.
package sudoku_pkg;

    localparam int PUZ_HEX_W      = 324;
    localparam int NUM_PIPE_STGS  = 6;
    localparam int NUM_CELLS      = 81;

    // Slot fields are sized for the largest supported configuration; the top uses the low bits.
    localparam int SLOT_SRC_MAX_W = 2;
    localparam int SLOT_TAG_MAX_W = 16;
    localparam int SLOT_CNT_MAX_W = 32;

    typedef struct packed {
        logic                      valid;
        logic [SLOT_SRC_MAX_W-1:0] src;
        logic [SLOT_TAG_MAX_W-1:0] tag;
        logic [SLOT_CNT_MAX_W-1:0] start;
    } slot_entry_t;

    function automatic logic grid_solved(input logic [PUZ_HEX_W-1:0] g);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (g[c*4 +: 4] == 4'd0) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/sudoku_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester found after ptr, wrapping.
module sudoku_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        int idx;
        grant = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if ((req & (ONE << idx)) != '0) grant = ONE << idx;
        end
    end

endmodule

// File: rtl/sudoku_sched.sv
// Front-end scheduler for sudoku_core: arbitrates requesters into a hold register,
// tracks puzzle ownership across the core's rotating slots and returns labelled results.
module sudoku_sched
    import sudoku_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int TAG_W     = 4,
    parameter int NUM_SLOTS = NUM_PIPE_STGS,
    parameter int CNT_W     = 16,
    parameter int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*PUZ_HEX_W-1:0] src_puzzle,
    input  logic [NUM_SRC*TAG_W-1:0]     src_tag,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         core_go,
    output logic                         core_puzzle_avail,
    output logic [PUZ_HEX_W-1:0]         core_puzzle_in,
    input  logic                         core_read_puzzle,
    input  logic                         core_done_puzzle,
    input  logic [PUZ_HEX_W-1:0]         core_puzzle_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [PUZ_HEX_W-1:0]         res_puzzle,
    output logic [SRC_W-1:0]             res_src,
    output logic [TAG_W-1:0]             res_tag,
    output logic                         res_solved,
    output logic [CNT_W-1:0]             res_cycles
);

    localparam int SP_W = $clog2(NUM_SLOTS);

    logic                 hold_valid_q, hold_valid_d;
    logic [PUZ_HEX_W-1:0] hold_puzzle_q, hold_puzzle_d;
    logic [SRC_W-1:0]     hold_src_q, hold_src_d;
    logic [TAG_W-1:0]     hold_tag_q, hold_tag_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SP_W-1:0]      sp_q, sp_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    slot_entry_t          slot_q [NUM_SLOTS];
    slot_entry_t          slot_d [NUM_SLOTS];
    logic                 res_valid_q, res_valid_d;
    logic [PUZ_HEX_W-1:0] res_puzzle_q, res_puzzle_d;
    logic [SRC_W-1:0]     res_src_q, res_src_d;
    logic [TAG_W-1:0]     res_tag_q, res_tag_d;
    logic                 res_solved_q, res_solved_d;
    logic [CNT_W-1:0]     res_cycles_q, res_cycles_d;

    logic                 refill;
    logic                 take;
    logic [NUM_SRC-1:0]   arb_req;
    logic [NUM_SRC-1:0]   arb_grant;
    logic [SRC_W-1:0]     grant_idx;
    logic [PUZ_HEX_W-1:0] sel_puzzle;
    logic [TAG_W-1:0]     sel_tag;
    slot_entry_t          cur_slot;
    slot_entry_t          new_slot;

    assign refill  = !hold_valid_q || core_read_puzzle;
    assign arb_req = src_valid & {NUM_SRC{refill}};

    sudoku_rr_arb #(
        .N     (NUM_SRC),
        .PTR_W (SRC_W)
    ) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    // Outputs are forced low while rst is held so nothing leaks through the combinational paths.
    assign src_ready         = rst ? '0 : arb_grant;
    assign take              = |(src_valid & src_ready);
    assign core_go           = enable && !rst;
    assign core_puzzle_avail = enable && !rst && (!res_valid_q || res_ready);
    assign core_puzzle_in    = hold_valid_q ? hold_puzzle_q : '0;

    assign res_valid  = res_valid_q;
    assign res_puzzle = res_puzzle_q;
    assign res_src    = res_src_q;
    assign res_tag    = res_tag_q;
    assign res_solved = res_solved_q;
    assign res_cycles = res_cycles_q;

    always_comb begin
        grant_idx  = '0;
        sel_puzzle = '0;
        sel_tag    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_grant[i]) begin
                grant_idx  = SRC_W'(i);
                sel_puzzle = src_puzzle[i*PUZ_HEX_W +: PUZ_HEX_W];
                sel_tag    = src_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_puzzle_d = hold_puzzle_q;
        hold_src_d    = hold_src_q;
        hold_tag_d    = hold_tag_q;
        rr_ptr_d      = rr_ptr_q;
        if (take) begin
            hold_valid_d  = 1'b1;
            hold_puzzle_d = sel_puzzle;
            hold_src_d    = grant_idx;
            hold_tag_d    = sel_tag;
            rr_ptr_d      = grant_idx;
        end else if (core_read_puzzle) begin
            hold_valid_d  = 1'b0;
        end
    end

    assign cur_slot = slot_q[sp_q];

    always_comb begin
        new_slot                  = '0;
        new_slot.valid            = hold_valid_q;
        new_slot.src[SRC_W-1:0]   = hold_src_q;
        new_slot.tag[TAG_W-1:0]   = hold_tag_q;
        new_slot.start[CNT_W-1:0] = cyc_q;
    end

    // The entry under sp is read out for a done event before the incoming puzzle replaces it.
    always_comb begin
        slot_d = slot_q;
        sp_d   = sp_q;
        cyc_d  = cyc_q + CNT_W'(1);
        if (core_read_puzzle) begin
            slot_d[sp_q] = new_slot;
            sp_d         = (sp_q == SP_W'(NUM_SLOTS - 1)) ? '0 : sp_q + SP_W'(1);
        end
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_puzzle_d = res_puzzle_q;
        res_src_d    = res_src_q;
        res_tag_d    = res_tag_q;
        res_solved_d = res_solved_q;
        res_cycles_d = res_cycles_q;
        if (core_done_puzzle && cur_slot.valid) begin
            res_valid_d  = 1'b1;
            res_puzzle_d = core_puzzle_out;
            res_src_d    = cur_slot.src[SRC_W-1:0];
            res_tag_d    = cur_slot.tag[TAG_W-1:0];
            res_solved_d = grid_solved(core_puzzle_out);
            res_cycles_d = cyc_q - cur_slot.start[CNT_W-1:0];
        end else if (res_ready) begin
            res_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q  <= 1'b0;
            hold_puzzle_q <= '0;
            hold_src_q    <= '0;
            hold_tag_q    <= '0;
            rr_ptr_q      <= '0;
            sp_q          <= '0;
            cyc_q         <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            res_valid_q   <= 1'b0;
            res_puzzle_q  <= '0;
            res_src_q     <= '0;
            res_tag_q     <= '0;
            res_solved_q  <= 1'b0;
            res_cycles_q  <= '0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_puzzle_q <= hold_puzzle_d;
            hold_src_q    <= hold_src_d;
            hold_tag_q    <= hold_tag_d;
            rr_ptr_q      <= rr_ptr_d;
            sp_q          <= sp_d;
            cyc_q         <= cyc_d;
            slot_q        <= slot_d;
            res_valid_q   <= res_valid_d;
            res_puzzle_q  <= res_puzzle_d;
            res_src_q     <= res_src_d;
            res_tag_q     <= res_tag_d;
            res_solved_q  <= res_solved_d;
            res_cycles_q  <= res_cycles_d;
        end
    end

endmodule
